// File: rtl/ipv4_hdr_parser_v2_pkg.sv
// Shared types and constants for the IPv4 header parser: FSM states, error bit
// positions, header byte offsets and the ones'-complement fold helper.
package ipv4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } ipv4_state_e;

    localparam int ERR_VERSION = 0;
    localparam int ERR_IHL     = 1;
    localparam int ERR_TRUNC   = 2;
    localparam int ERR_CSUM    = 3;

    localparam logic [7:0] IPV4_OFF_VER   = 8'd0;
    localparam logic [7:0] IPV4_OFF_LEN   = 8'd2;
    localparam logic [7:0] IPV4_OFF_FRAG  = 8'd6;
    localparam logic [7:0] IPV4_OFF_TTL   = 8'd8;
    localparam logic [7:0] IPV4_OFF_PROTO = 8'd9;
    localparam logic [7:0] IPV4_OFF_SRC   = 8'd12;
    localparam logic [7:0] IPV4_OFF_DST   = 8'd16;
    localparam logic [7:0] IPV4_MIN_HLEN  = 8'd20;

    // Second fold cannot carry: a carry out of the first fold leaves at most 0x000E below it.
    function automatic logic [15:0] ones_fold(input logic [19:0] s);
        logic [16:0] f1;
        logic [15:0] f2;
        f1 = {1'b0, s[15:0]} + {13'b0, s[19:16]};
        f2 = f1[15:0] + {15'b0, f1[16]};
        return f2;
    endfunction

endpackage

// File: rtl/ipv4_hdr_parser_v2_if.sv
// Stream-in / stream-out / header-result bundle of the IPv4 header parser.
interface ipv4_hdr_parser_v2_if #(
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = $clog2(DATA_WIDTH/8+1)
);
    logic [DATA_WIDTH-1:0] tdata_in;
    logic [IDX_W-1:0]      idx_in;
    logic                  data_valid_in;
    logic                  last_flag_in;
    logic                  eth_parser_ready;

    logic [DATA_WIDTH-1:0] tdata_out;
    logic [IDX_W-1:0]      idx_out;
    logic                  data_valid_out;
    logic                  last_flag_out;

    logic                  hdr_ready;
    logic                  hdr_valid;
    logic [IDX_W-1:0]      l4_offset;
    logic [3:0]            version;
    logic [3:0]            ihl;
    logic [15:0]           total_length;
    logic [7:0]            ttl;
    logic [7:0]            protocol;
    logic [2:0]            flags;
    logic [12:0]           frag_offset;
    logic [31:0]           src_ip;
    logic [31:0]           dst_ip;
    logic [3:0]            hdr_err;

    modport master (
        output tdata_in, idx_in, data_valid_in, last_flag_in, eth_parser_ready,
        input  tdata_out, idx_out, data_valid_out, last_flag_out,
        input  hdr_ready, hdr_valid, l4_offset, version, ihl, total_length,
        input  ttl, protocol, flags, frag_offset, src_ip, dst_ip, hdr_err
    );

    modport slave (
        input  tdata_in, idx_in, data_valid_in, last_flag_in, eth_parser_ready,
        output tdata_out, idx_out, data_valid_out, last_flag_out,
        output hdr_ready, hdr_valid, l4_offset, version, ihl, total_length,
        output ttl, protocol, flags, frag_offset, src_ip, dst_ip, hdr_err
    );
endinterface

// File: rtl/ipv4_hdr_parser_v2_csum_acc.sv
// Per-beat ones'-complement accumulation of IPv4 header words; sum reflects the
// current beat combinationally so the check adds no latency.
module ipv4_csum_acc #(
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = $clog2(DATA_WIDTH/8+1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic [IDX_W-1:0]      idx,
    input  logic [5:0]            cnt,
    input  logic [7:0]            hlen,
    input  logic                  en,
    input  logic                  first,
    output logic [19:0]           sum
);
    localparam int NB = DATA_WIDTH/8;

    logic [19:0] acc_r;
    logic [23:0] beat_s;
    logic [23:0] total_s;
    logic [7:0]  off_s;

    // Even header offsets are the high byte of a 16-bit word.
    always_comb begin
        beat_s = 24'd0;
        off_s  = 8'd0;
        for (int i = 0; i < NB; i++) begin
            off_s = {2'b00, cnt} + 8'(i);
            if ((IDX_W'(i) < idx) && (off_s < hlen)) begin
                beat_s = beat_s + (off_s[0] ? {16'd0, tdata[i*8 +: 8]} : {8'd0, tdata[i*8 +: 8], 8'd0});
            end else begin
                beat_s = beat_s;
            end
        end
        total_s = (first ? 24'd0 : {4'd0, acc_r}) + beat_s;
        sum     = {4'd0, total_s[15:0]} + {12'd0, total_s[23:16]};
    end

    // Partially folded running sum, restarted by the first beat of a header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 20'd0;
        end else if (en) begin
            acc_r <= sum;
        end
    end
endmodule

// File: rtl/ipv4_hdr_parser_v2.sv
// IPv4 header parser for an LSB-first byte stream of any width, with 1-cycle
// pass-through. Define IPV4_CSUM_CHECK_EN to enable header checksum checking.
module ipv4_hdr_parser_v2
    import ipv4_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = $clog2(DATA_WIDTH/8+1)
) (
    input logic                 clk,
    input logic                 rst_n,
    ipv4_hdr_parser_v2_if.slave bus
);
    localparam int NB = DATA_WIDTH/8;

    ipv4_state_e state_r;
    logic [5:0]  cnt_r;

    logic        proc_s;
    logic        first_s;
    logic [3:0]  ver_eff_s;
    logic [3:0]  ihl_eff_s;
    logic [7:0]  hlen_s;
    logic [7:0]  sum_s;
    logic        done_s;
    logic        csum_bad_s;
    logic [3:0]  err_s;
    logic [3:0]  trunc_err_s;
    logic [7:0]  off_s [NB];
    logic [NB-1:0] bv_s;

`ifdef IPV4_CSUM_CHECK_EN
    logic [19:0] csum_s;

    ipv4_csum_acc #(.DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .tdata (bus.tdata_in),
        .idx   (bus.idx_in),
        .cnt   (cnt_r),
        .hlen  (hlen_s),
        .en    (proc_s),
        .first (state_r == ST_IDLE),
        .sum   (csum_s)
    );
    assign csum_bad_s = (ones_fold(csum_s) != 16'hFFFF);
`else
    assign csum_bad_s = 1'b0;
`endif

    // Beat decode; version/ihl come straight from the bus when offset 0 is in this beat.
    always_comb begin
        proc_s  = bus.data_valid_in && bus.eth_parser_ready && (state_r != ST_PAYLOAD);
        first_s = proc_s && (cnt_r == 6'd0) && (bus.idx_in != '0);
        if (first_s) begin
            ver_eff_s = bus.tdata_in[7:4];
            ihl_eff_s = bus.tdata_in[3:0];
        end else begin
            ver_eff_s = bus.version;
            ihl_eff_s = bus.ihl;
        end
        hlen_s = (ihl_eff_s < 4'd5) ? IPV4_MIN_HLEN : {2'b00, ihl_eff_s, 2'b00};
        sum_s  = {2'b00, cnt_r} + 8'(bus.idx_in);
        done_s = (sum_s >= hlen_s);
        err_s              = 4'd0;
        err_s[ERR_VERSION] = (ver_eff_s != 4'd4);
        err_s[ERR_IHL]     = (ihl_eff_s < 4'd5);
        err_s[ERR_CSUM]    = csum_bad_s;
        trunc_err_s            = err_s;
        trunc_err_s[ERR_CSUM]  = 1'b0;
        trunc_err_s[ERR_TRUNC] = 1'b1;
        for (int i = 0; i < NB; i++) begin
            off_s[i] = {2'b00, cnt_r} + 8'(i);
            bv_s[i]  = (IDX_W'(i) < bus.idx_in);
        end
    end

    // Registered pass-through of the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tdata_out      <= '0;
            bus.idx_out        <= '0;
            bus.data_valid_out <= 1'b0;
            bus.last_flag_out  <= 1'b0;
        end else begin
            bus.tdata_out      <= bus.tdata_in;
            bus.idx_out        <= bus.idx_in;
            bus.data_valid_out <= bus.data_valid_in;
            bus.last_flag_out  <= bus.last_flag_in;
        end
    end

    // Field capture by header offset; fields hold until the next header overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.version      <= 4'd0;
            bus.ihl          <= 4'd0;
            bus.total_length <= 16'd0;
            bus.flags        <= 3'd0;
            bus.frag_offset  <= 13'd0;
            bus.ttl          <= 8'd0;
            bus.protocol     <= 8'd0;
            bus.src_ip       <= 32'd0;
            bus.dst_ip       <= 32'd0;
        end else if (proc_s) begin
            for (int i = 0; i < NB; i++) begin
                if (bv_s[i]) begin
                    case (off_s[i])
                        IPV4_OFF_VER: begin
                            bus.version <= bus.tdata_in[i*8+4 +: 4];
                            bus.ihl     <= bus.tdata_in[i*8 +: 4];
                        end
                        IPV4_OFF_LEN:         bus.total_length[15:8] <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_LEN + 8'd1:  bus.total_length[7:0]  <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_FRAG: begin
                            bus.flags             <= bus.tdata_in[i*8+5 +: 3];
                            bus.frag_offset[12:8] <= bus.tdata_in[i*8 +: 5];
                        end
                        IPV4_OFF_FRAG + 8'd1: bus.frag_offset[7:0]   <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_TTL:         bus.ttl                <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_PROTO:       bus.protocol           <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_SRC:         bus.src_ip[31:24]      <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_SRC + 8'd1:  bus.src_ip[23:16]      <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_SRC + 8'd2:  bus.src_ip[15:8]       <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_SRC + 8'd3:  bus.src_ip[7:0]        <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_DST:         bus.dst_ip[31:24]      <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_DST + 8'd1:  bus.dst_ip[23:16]      <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_DST + 8'd2:  bus.dst_ip[15:8]       <= bus.tdata_in[i*8 +: 8];
                        IPV4_OFF_DST + 8'd3:  bus.dst_ip[7:0]        <= bus.tdata_in[i*8 +: 8];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Packet FSM; loss of eth_parser_ready overrides every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 6'd0;
            bus.hdr_valid <= 1'b0;
            bus.hdr_ready <= 1'b0;
            bus.l4_offset <= '0;
            bus.hdr_err   <= 4'd0;
        end else begin
            bus.hdr_valid <= 1'b0;
            if (!bus.eth_parser_ready) begin
                state_r       <= ST_IDLE;
                cnt_r         <= 6'd0;
                bus.hdr_ready <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_HDR: begin
                        if (bus.data_valid_in) begin
                            if (done_s) begin
                                bus.hdr_valid <= 1'b1;
                                bus.hdr_ready <= 1'b1;
                                bus.l4_offset <= IDX_W'(hlen_s - {2'b00, cnt_r});
                                bus.hdr_err   <= err_s;
                                cnt_r         <= 6'd0;
                                state_r       <= bus.last_flag_in ? ST_IDLE : ST_PAYLOAD;
                            end else if (bus.last_flag_in) begin
                                bus.hdr_valid <= 1'b1;
                                bus.hdr_ready <= 1'b0;
                                bus.hdr_err   <= trunc_err_s;
                                cnt_r         <= 6'd0;
                                state_r       <= ST_IDLE;
                            end else begin
                                bus.hdr_ready <= 1'b0;
                                cnt_r         <= sum_s[5:0];
                                state_r       <= ST_HDR;
                            end
                        end else if (state_r == ST_IDLE) begin
                            bus.hdr_ready <= 1'b0;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (bus.data_valid_in && bus.last_flag_in) begin
                            state_r       <= ST_IDLE;
                            bus.hdr_ready <= 1'b0;
                        end
                    end
                    default: begin
                        state_r       <= ST_IDLE;
                        cnt_r         <= 6'd0;
                        bus.hdr_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
